// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port bundle: req/ack handshake plus address, write data and read data.
// master = requester (CPU controller or loader), slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the CPU's single-port unified memory (m0 = CPU, m1 = loader/DMA).
// Define MEM_PORT_ARBITER_PERF_EN to build the grant/conflict performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_id,
    output logic              busy,
    output logic [15:0]       perf_m0_cnt,
    output logic [15:0]       perf_m1_cnt,
    output logic [15:0]       perf_conf_cnt
);

    // state   | meaning
    // S_IDLE  | no access in flight; arbitrate and latch the winner's request
    // S_ISSUE | mem_en high for this single cycle; load the latency counter
    // S_WAIT  | count down MEM_LAT; capture mem_rdata when the count hits 1
    // S_RESP  | one-cycle ack to the winner
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic [3:0] wait_cnt;
    logic       any_req;
    logic       both_req;
    logic       win;

    assign any_req  = m0.req | m1.req;
    assign both_req = m0.req & m1.req;

    always_comb begin
        win = 1'b0;
        if (both_req)
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        else if (m1.req)
            win = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0.ack     <= 1'b0;
            m1.ack     <= 1'b0;
            m0.rdata   <= '0;
            m1.rdata   <= '0;
        end else begin
            m0.ack <= 1'b0;
            m1.ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id   <= win;
                        last_grant <= win;
                        mem_we     <= win ? m1.we    : m0.we;
                        mem_addr   <= win ? m1.addr  : m0.addr;
                        mem_wdata  <= win ? m1.wdata : m0.wdata;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_en   <= 1'b0;
                    wait_cnt <= 4'(MEM_LAT);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    // Writes also capture here; the value is simply ignored by the requester.
                    if (wait_cnt == 4'd1) begin
                        if (grant_id) begin
                            m1.rdata <= mem_rdata;
                            m1.ack   <= 1'b1;
                        end else begin
                            m0.rdata <= mem_rdata;
                            m0.ack   <= 1'b1;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic grant_now;
    assign grant_now = (state == S_IDLE) && any_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_m0_cnt   <= 16'd0;
            perf_m1_cnt   <= 16'd0;
            perf_conf_cnt <= 16'd0;
        end else if (grant_now) begin
            if (!win && perf_m0_cnt != 16'hFFFF)
                perf_m0_cnt <= perf_m0_cnt + 16'd1;
            if (win && perf_m1_cnt != 16'hFFFF)
                perf_m1_cnt <= perf_m1_cnt + 16'd1;
            if (both_req && perf_conf_cnt != 16'hFFFF)
                perf_conf_cnt <= perf_conf_cnt + 16'd1;
        end
    end
`else
    assign perf_m0_cnt   = 16'd0;
    assign perf_m1_cnt   = 16'd0;
    assign perf_conf_cnt = 16'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters: m0, the CPU controller's memory port (IorD-muxed address), and m1, the program loader/DMA port.
- Serialises accesses with a req/ack handshake, drives the memory's one synchronous port, and returns read data to the winner.
- A pending CPU access without ack is a stall to the CPU controller.

Parameters:
- ADDR_W, 32, memory address width in bits.
- DATA_W, 32, memory data width in bits.
- MEM_LAT, 1, cycles from mem_en being sampled to mem_rdata valid; legal range 1..15.
- FIXED_PRIO, 0. 0 selects round-robin. 1 makes m0 always win ties.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  CPU access request; held until m0_ack
- m0_we  in  1  CPU write enable (1 = write)
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_ack  out  1  one-cycle completion pulse to the CPU
- m0_rdata  out  DATA_W  CPU read data, valid while m0_ack = 1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: as for m0, for the loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- grant_id  out  1  requester currently owning the memory
- busy  out  1  high in any state other than S_IDLE
- perf_m0_cnt, perf_m1_cnt, perf_conf_cnt  out  16 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async, immediate) forces the following, abandoning any in-flight access:
  - state = S_IDLE
  - all outputs 0: acks, mem_en, mem_we, mem_addr, mem_wdata, rdata, grant_id, busy
  - last_grant = 1, so m0 wins the first tie
  - wait counter = 0
- All outputs are registered.
- FSM state S_IDLE:
  - No req: stay.
  - Any req: pick a winner and latch its id, we, addr and wdata into grant_id, mem_we, mem_addr, mem_wdata. Go to S_ISSUE.
  - Only one req: that requester wins.
  - Both req, FIXED_PRIO = 0: winner = !last_grant.
  - Both req, FIXED_PRIO = 1: m0 wins.
  - last_grant is updated to the winner.
- FSM state S_ISSUE:
  - mem_en = 1 for exactly one cycle.
  - Load the wait counter with MEM_LAT. Go to S_WAIT.
- FSM state S_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the winner's rdata register and go to S_RESP.
  - MEM_LAT = 1 therefore spends exactly one cycle in S_WAIT.
- FSM state S_RESP:
  - Winner's ack = 1 for one cycle. Go to S_IDLE.
  - The loser's ack and rdata are untouched.
- Latency: req first high in cycle 0 with the FSM in S_IDLE gives ack in cycle 2+MEM_LAT (3 by default). A back-to-back access costs 3+MEM_LAT cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - It must drop req in the cycle after ack. A req still high in S_IDLE is a new request.
  - Changes to the winner's inputs after the latch in S_IDLE are ignored.
  - A loser's req stays pending without limit. Dropping req before ack is legal only for the loser, and means withdrawal.
- Writes:
  - mem_we is held from S_ISSUE through S_RESP but is meaningful only while mem_en = 1.
  - A write still waits the full MEM_LAT before ack. rdata is still captured, and its value is don't-care.
- rdata registers hold their last value between acks.
- Reset mid-access: mem_en drops immediately, and no ack is produced for the abandoned access.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- With the macro defined:
  - perf_m0_cnt and perf_m1_cnt increment on each grant to that requester.
  - perf_conf_cnt increments on each S_IDLE cycle in which both reqs are high and a grant is made.
  - All three counters saturate at 16'hFFFF and clear on reset.
- Without the macro: all three outputs are constant 0 and no counter flops exist.

Test Plan:
- Single read: m0_req = 1, we = 0, addr = 0x10, memory returns 0xDEADBEEF.
  - mem_en is high exactly in cycle 1 with mem_addr = 0x10.
  - m0_ack is high in cycle 3 with m0_rdata = 0xDEADBEEF. m1_ack stays 0.
- Single write: m1 writes 0x12345678 to 0x40.
  - mem_en = mem_we = 1 for one cycle with the correct address and data.
  - m1_ack is high in cycle 3. A following m0 read of 0x40 returns 0x12345678.
- Contention after reset, both reqs held continuously, FIXED_PRIO = 0:
  - Grants run m0, m1, m0, m1; acks are 4 cycles apart; grant_id toggles.
  - With FIXED_PRIO = 1, m1 is granted only after m0 drops req.
- MEM_LAT = 3, read of 0x8:
  - Ack in cycle 5. Data is captured from mem_rdata 3 cycles after mem_en. mem_en is high for only one cycle.
- Reset mid-access:
  - Assert reset during S_WAIT: all outputs go to 0 at once, with no clock edge needed.
  - After release, a held m1_req and m0_req are both high; m0 is granted first because last_grant resets to 1.
- MEM_PORT_ARBITER_PERF_EN defined, 3 contended rounds: perf_m0_cnt = 3, perf_m1_cnt = 3, perf_conf_cnt = 5 (the last m1 grant is uncontended).
